// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants for the CHIP-8 hex keypad scanner.
//   key_code_t      : 4-bit CHIP-8 key code
//   KEY_MAP         : [row][col] -> key code for the 4x4 board matrix
//   KEY_FIFO_DEPTH  : depth of the press-event FIFO
package keypad_pkg;

  typedef logic [3:0] key_code_t;

  // Board layout, rows top to bottom, columns left to right.
  localparam key_code_t KEY_MAP [0:3][0:3] = '{
    '{4'h1, 4'h2, 4'h3, 4'hC},
    '{4'h4, 4'h5, 4'h6, 4'hD},
    '{4'h7, 4'h8, 4'h9, 4'hE},
    '{4'hA, 4'h0, 4'hB, 4'hF}
  };

  localparam int KEY_FIFO_DEPTH = 4;

endpackage

// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: CPU-facing side of the keypad scanner.
//   keys      : debounced level vector, bit n = CHIP-8 key n held
//   evt_valid : press event available at the FIFO head
//   evt_code  : CHIP-8 code of the head event
//   evt_ready : consumer accepts the head event
//   overflow  : sticky, a press event was dropped
// master = scanner, slave = CPU.
import keypad_pkg::*;

interface keypad_scanner_if;
  logic [15:0] keys;
  logic        evt_valid;
  key_code_t   evt_code;
  logic        evt_ready;
  logic        overflow;

  modport master (output keys, evt_valid, evt_code, overflow, input  evt_ready);
  modport slave  (input  keys, evt_valid, evt_code, overflow, output evt_ready);
endinterface

// File: rtl/key_evt_fifo.sv
// key_evt_fifo: small in-order event FIFO with sticky overflow.
//   clk, rst   : clock, async active-high reset
//   push, din  : write request and data (dropped when full without a pop)
//   pop_ready  : consumer ready; a pop happens on valid & pop_ready
//   valid, head: not-empty flag and head entry
//   overflow   : sticky, set when a push is dropped; cleared only by reset
import keypad_pkg::*;

module key_evt_fifo #(
  parameter int DEPTH = KEY_FIFO_DEPTH,
  parameter int W     = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop_ready,
  output logic         valid,
  output logic [W-1:0] head,
  output logic         overflow
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, count_nxt;
  logic          full;
  logic          do_pop, do_push;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A pop frees the slot in the same cycle, so a push into a full FIFO
  // that is also being popped is accepted.
  assign do_pop  = valid & pop_ready;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (do_push & ~do_pop)      count_nxt = count + 1'b1;
    else if (~do_push & do_pop) count_nxt = count - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      valid    <= 1'b0;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      count <= count_nxt;
      valid <= (count_nxt != '0);
      full  <= (count_nxt == CW'(DEPTH));
      if (push & ~do_push) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans the 4x4 CHIP-8 key matrix, debounces each key,
// publishes the level vector and a FIFO of press events.
//   fpga_clk, rst_in : clock, async active-high reset
//   row              : matrix rows (pulled up, low = closed on driven column)
//   col              : active-low one-hot column drive
//   evt              : keypad_scanner_if.master (keys, evt_*, overflow)
// Build option: define KEYPAD_DEBOUNCE_EN for per-key debounce counters;
// without it each key's stable state simply follows its latest sample.
import keypad_pkg::*;

module keypad_scanner #(
  parameter int DWELL    = 4096,
  parameter int DEBOUNCE = 4
) (
  input  logic                    fpga_clk,
  input  logic                    rst_in,
  input  logic [3:0]              row,
  output logic [3:0]              col,
  keypad_scanner_if.master        evt
);
  localparam int DW = $clog2(DWELL);

  if (DWELL < 8)    begin : g_chk_dwell    $error("DWELL must be >= 8");    end
  if (DEBOUNCE < 1) begin : g_chk_debounce $error("DEBOUNCE must be >= 1"); end

  logic [DW-1:0]   d;
  logic [1:0]      c;
  logic            sample;
  logic [3:0]      row_s1, row_s2;
  logic [3:0]      raw;
  logic [3:0][3:0] stable;      // [row][col]
  logic [3:0]      flip, rise;
  logic [3:0]      pending;
  logic [1:0]      pend_col;
  logic [3:0]      pop_mask;
  logic [1:0]      pop_row;
  logic            push;
  key_code_t       push_code;
  logic [15:0]     keys_w;

  assign sample = (d == DW'(DWELL - 1));

  // Rows are board pins; two flops keep them out of the debounce logic.
  // The dwell is long enough that the synchronised value at the sample
  // edge still belongs to the column currently being driven.
  assign raw = ~row_s2;

`ifdef KEYPAD_DEBOUNCE_EN
  localparam int CNTW = $clog2(DEBOUNCE + 1);
  logic [CNTW-1:0] cnt [4][4];
  logic [CNTW-1:0] cnt_nxt [4];

  // Counter reaching DEBOUNCE is detected one step early so it never
  // has to hold the terminal value.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      flip[r]    = 1'b0;
      cnt_nxt[r] = '0;
      if (raw[r] != stable[r][c]) begin
        if (cnt[r][c] == CNTW'(DEBOUNCE - 1)) flip[r] = 1'b1;
        else                                  cnt_nxt[r] = cnt[r][c] + 1'b1;
      end
    end
  end

  always_ff @(posedge fpga_clk or posedge rst_in) begin
    if (rst_in) begin
      for (int r = 0; r < 4; r++)
        for (int k = 0; k < 4; k++) cnt[r][k] <= '0;
    end else if (sample) begin
      for (int r = 0; r < 4; r++) cnt[r][c] <= cnt_nxt[r];
    end
  end
`else
  always_comb begin
    for (int r = 0; r < 4; r++) flip[r] = (raw[r] != stable[r][c]);
  end
`endif

  assign rise = flip & raw;

  // Lowest pending row drains first, one per cycle.
  always_comb begin
    pop_row = 2'd0;
    for (int r = 3; r >= 0; r--) if (pending[r]) pop_row = 2'(r);
    pop_mask = pending & (~pending + 4'd1);
  end

  assign push      = |pending;
  assign push_code = KEY_MAP[pop_row][pend_col];

  always_ff @(posedge fpga_clk or posedge rst_in) begin
    if (rst_in) begin
      d        <= '0;
      c        <= 2'd0;
      col      <= 4'b1110;
      row_s1   <= 4'hF;
      row_s2   <= 4'hF;
      stable   <= '0;
      pending  <= '0;
      pend_col <= 2'd0;
    end else begin
      row_s1 <= row;
      row_s2 <= row_s1;
      if (sample) begin
        d <= '0;
        c <= c + 2'd1;
        col <= ~(4'b0001 << (c + 2'd1));
        for (int r = 0; r < 4; r++) stable[r][c] <= stable[r][c] ^ flip[r];
        // Previous mask has long drained: it empties in <= 4 cycles.
        pending  <= rise;
        pend_col <= c;
      end else begin
        d       <= d + 1'b1;
        pending <= pending & ~pop_mask;
      end
    end
  end

  always_comb begin
    keys_w = '0;
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 4; k++) keys_w[KEY_MAP[r][k]] = stable[r][k];
  end

  assign evt.keys = keys_w;

  key_evt_fifo #(.DEPTH(KEY_FIFO_DEPTH), .W(4)) u_fifo (
    .clk       (fpga_clk),
    .rst       (rst_in),
    .push      (push),
    .din       (push_code),
    .pop_ready (evt.evt_ready),
    .valid     (evt.evt_valid),
    .head      (evt.evt_code),
    .overflow  (evt.overflow)
  );

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a behavioural key matrix drives row from col,
// expected press codes go into a queue, and a monitor pops and compares
// on every accepted event.
import keypad_pkg::*;

module tb_keypad_scanner;
  localparam int DWELL    = 8;
  localparam int DEBOUNCE = 2;
  localparam int SCAN     = 4 * DWELL;

  logic            fpga_clk = 1'b0;
  logic            rst_in;
  logic [3:0]      row, col;
  logic [3:0][3:0] pressed;     // [row][col]
  int              checks = 0;
  int              errors = 0;
  key_code_t       exp_q [$];

  keypad_scanner_if bus ();

  keypad_scanner #(.DWELL(DWELL), .DEBOUNCE(DEBOUNCE)) dut (
    .fpga_clk (fpga_clk),
    .rst_in   (rst_in),
    .row      (row),
    .col      (col),
    .evt      (bus)
  );

  always #5 fpga_clk = ~fpga_clk;

  // A closed key pulls its row low while its column is driven low.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++) row[r] = ~|(pressed[r] & ~col);
  end

  always @(negedge fpga_clk) begin
    key_code_t e;
    if (!rst_in && bus.evt_valid && bus.evt_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL evt_unexpected got=%h exp=none", bus.evt_code);
      end else begin
        e = exp_q.pop_front();
        if (bus.evt_code !== e) begin
          errors++;
          $display("FAIL evt_code got=%h exp=%h", bus.evt_code, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge fpga_clk);
    #1;
  endtask

  // Wait until (col == want) equals eq, bounded.
  task automatic wait_col(input logic [3:0] want, input bit eq);
    int n = 0;
    do begin
      @(posedge fpga_clk); #1; n++;
    end while (((col == want) != eq) && n < 200);
    if ((col == want) != eq) begin
      checks++; errors++;
      $display("FAIL wait_col_timeout got=%b exp=%b", col, want);
    end
  endtask

  initial begin
    int n;
    pressed       = '0;
    bus.evt_ready = 1'b0;
    rst_in        = 1'b1;
    cyc(3);
    chk("rst_col",   32'(col), 32'hE);
    chk("rst_keys",  32'(bus.keys), 32'h0);
    chk("rst_valid", 32'(bus.evt_valid), 32'h0);
    chk("rst_code",  32'(bus.evt_code), 32'h0);
    chk("rst_ovf",   32'(bus.overflow), 32'h0);
    rst_in = 1'b0;

    // Async reset mid-dwell with a key held and an event queued.
    pressed[0][1] = 1'b1;
    cyc(4 * SCAN);
    chk("pre_rst_keys",  32'(bus.keys), 32'h0004);
    chk("pre_rst_valid", 32'(bus.evt_valid), 32'h1);
    @(posedge fpga_clk); #3;
    rst_in = 1'b1;
    #1;
    chk("async_rst_col",   32'(col), 32'hE);
    chk("async_rst_keys",  32'(bus.keys), 32'h0);
    chk("async_rst_valid", 32'(bus.evt_valid), 32'h0);
    chk("async_rst_ovf",   32'(bus.overflow), 32'h0);
    chk("async_rst_code",  32'(bus.evt_code), 32'h0);
    pressed = '0;
    cyc(2);
    rst_in = 1'b0;

    // Single press of key 2, consumed immediately.
    bus.evt_ready = 1'b1;
    exp_q.push_back(4'h2);
    pressed[0][1] = 1'b1;
    cyc(4 * SCAN);
    chk("single_keys", 32'(bus.keys), 32'h0004);
    pressed = '0;
    cyc(4 * SCAN);
    chk("single_release_keys", 32'(bus.keys), 32'h0);
    chk("single_q_empty", 32'(exp_q.size()), 32'h0);

`ifdef KEYPAD_DEBOUNCE_EN
    // One col0 sample of key 7 only: rejected.
    wait_col(4'b1110, 1'b0);
    wait_col(4'b1110, 1'b1);
    pressed[2][0] = 1'b1;
    wait_col(4'b1110, 1'b0);
    pressed = '0;
    cyc(3 * SCAN);
    chk("bounce_keys", 32'(bus.keys), 32'h0);
    chk("bounce_q_empty", 32'(exp_q.size()), 32'h0);
`else
    // One col3 sample of key D is enough without debounce.
    exp_q.push_back(4'hD);
    wait_col(4'b0111, 1'b0);
    wait_col(4'b0111, 1'b1);
    pressed[1][3] = 1'b1;
    wait_col(4'b0111, 1'b0);
    pressed = '0;
    chk("nodeb_keys", 32'(bus.keys), 32'h2000);
    cyc(2 * SCAN);
    chk("nodeb_release_keys", 32'(bus.keys), 32'h0);
    chk("nodeb_q_empty", 32'(exp_q.size()), 32'h0);
`endif

    // Same-column multi-press: rows 0 and 3 on column 1 -> 2 then 0.
    exp_q.push_back(4'h2);
    exp_q.push_back(4'h0);
    pressed[0][1] = 1'b1;
    pressed[3][1] = 1'b1;
    cyc(4 * SCAN);
    chk("multi_keys", 32'(bus.keys), 32'h0005);
    pressed = '0;
    cyc(4 * SCAN);
    chk("multi_q_empty", 32'(exp_q.size()), 32'h0);

    // Overflow: five presses into a stalled FIFO, fifth is dropped.
    bus.evt_ready = 1'b0;
    pressed[0][0] = 1'b1; cyc(4 * SCAN);
    pressed[1][0] = 1'b1; cyc(4 * SCAN);
    pressed[2][0] = 1'b1; cyc(4 * SCAN);
    pressed[3][0] = 1'b1; cyc(4 * SCAN);
    chk("ovf_before", 32'(bus.overflow), 32'h0);
    pressed[0][1] = 1'b1; cyc(4 * SCAN);
    chk("ovf_after", 32'(bus.overflow), 32'h1);
    chk("ovf_keys",  32'(bus.keys), 32'h0496);
    chk("ovf_valid", 32'(bus.evt_valid), 32'h1);
    exp_q.push_back(4'h1);
    exp_q.push_back(4'h4);
    exp_q.push_back(4'h7);
    exp_q.push_back(4'hA);

    // Press F and pop exactly on the cycle its event is pushed into the
    // full FIFO: the sample edge that raises keys[15] is followed by the push.
    pressed[3][3] = 1'b1;
    n = 0;
    do begin
      @(posedge fpga_clk); #1; n++;
    end while (!bus.keys[15] && n < 8 * SCAN);
    chk("keyF_seen", 32'(bus.keys[15]), 32'h1);
    exp_q.push_back(4'hF);
    bus.evt_ready = 1'b1;
    @(posedge fpga_clk); #1;
    bus.evt_ready = 1'b0;
    chk("full_swap_valid", 32'(bus.evt_valid), 32'h1);
    chk("full_swap_code",  32'(bus.evt_code), 32'h4);
    cyc(2);
    bus.evt_ready = 1'b1;
    cyc(10);
    chk("drain_valid", 32'(bus.evt_valid), 32'h0);
    chk("drain_q_empty", 32'(exp_q.size()), 32'h0);
    chk("ovf_sticky", 32'(bus.overflow), 32'h1);
    pressed = '0;
    cyc(4 * SCAN);
    chk("final_keys", 32'(bus.keys), 32'h0);
    chk("final_q_empty", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans the 4x4 CHIP-8 hex key matrix, debounces every key, and publishes two things to the CPU. The first is a 16-bit level vector indexed by CHIP-8 key code, used by Ex9E/ExA1. The second is a valid/ready stream of key-press codes, buffered in a 4-deep FIFO, used by Fx0A. The block sits between the board's row/col pins and the cpu, and runs directly on fpga_clk.

## Interface
- DWELL, 4096: fpga_clk cycles each column is driven; minimum 8.
- DEBOUNCE, 4: consecutive disagreeing samples required to flip a key's stable state; minimum 1.
- fpga_clk  in  1  sole clock, rising edge.
- rst_in  in  1  reset, asynchronous, active-high.
- row  in  4  matrix rows, pulled up; low = key closed on driven column.
- col  out  4  column drive, active-low one-hot.
- keys  out  16  debounced state, bit n = CHIP-8 key n held.
- evt_valid  out  1  press event available.
- evt_code  out  4  CHIP-8 code of head event.
- evt_ready  in  1  consumer accepts head event.
- overflow  out  1  sticky: a press event was dropped.

## Operation
- Scan: column index c (0..3) and dwell counter d (0..DWELL-1).
  - col = ~(4'b1 << c).
  - At d == DWELL-1: sample raw[r] = ~row[r] for r = 0..3, set d = 0, and advance c mod 4 (3 wraps to 0).
  - One full matrix scan = 4*DWELL cycles.
- Mapping (row r, column c) -> code, via KEY_MAP:
  - r0: 1 2 3 C
  - r1: 4 5 6 D
  - r2: 7 8 9 E
  - r3: A 0 B F
- Debounce, per key, updated only on its column's sample cycle:
  - Agree (raw == stable): counter = 0.
  - Disagree: counter + 1; when the counter reaches DEBOUNCE, flip stable and clear the counter.
  - Counter width = $clog2(DEBOUNCE+1).
- Press event: a stable 0->1 flip sets that row's bit in a 4-bit pending mask.
  - On each following cycle, the lowest set bit pops from the mask and pushes its code into the FIFO.
  - The mask drains within 4 cycles, before the next sample, because DWELL >= 8.
  - Releases (1->0) produce no event.
- FIFO: depth 4, in order.
  - evt_valid = not empty; evt_code = head entry.
  - Pop on evt_valid & evt_ready.
  - Push when full and no pop in the same cycle: the entry is dropped and overflow is set. overflow clears only on reset.
  - Push and pop in the same cycle while full: both take effect, the count is unchanged, and no overflow is raised.
  - Push into empty: the data appears at the head on the next cycle.
- Reset, asynchronous, may land mid-scan or mid-drain. It forces:
  - c = 0, d = 0, col = 4'b1110
  - all stable bits and counters = 0, pending mask = 0
  - keys = 0, FIFO emptied, evt_valid = 0, evt_code = 0, overflow = 0

## Timing
- All outputs are registered; nothing combinational runs from row to any output.
- keys bit updates on the cycle after the sample edge that completes debounce.
- Push happens 1-4 cycles after that update (row order); evt_valid rises the cycle after the push.
- Worst-case press latency: DEBOUNCE*4*DWELL + 4*DWELL + 5 cycles from the first stable closure.
- A held key produces exactly one event. A release followed by a re-press produces a new event once debounced.

## Configuration
- KEYPAD_DEBOUNCE_EN
  - Defined: per-key counters and the DEBOUNCE rule as above.
  - Undefined: no counters, DEBOUNCE ignored, and stable = raw at each sample. Events still fire on 0->1 of stable.

## Structure
- keypad_pkg holds:
  - typedef key_code_t (logic [3:0])
  - KEY_MAP: 4x4 constant array of key_code_t, indexed [row][col]
  - FIFO depth constant KEY_FIFO_DEPTH = 4
- Sub-module key_evt_fifo: parameterised on depth, with push/pop, full/empty and overflow logic.
- Scanning, debounce and the pending mask live in keypad_scanner itself.

## Test plan
All scenarios use DWELL=8 and DEBOUNCE=2 unless noted.
- Reset: assert rst_in asynchronously mid-dwell with keys held -> immediately col=1110, keys=0, evt_valid=0, overflow=0.
- Single press: hold row[0] low while col[1] is low for 2 scans -> keys[2]=1 after the 2nd col1 sample; evt_valid=1 with evt_code=2; with evt_ready=1 it pops and exactly one event is seen.
- Bounce rejection (macro defined): row[2] low during one col0 sample only -> keys stays 0 and no event.
- Same-column multi-press: rows 0 and 3 closed on column 1 simultaneously -> evt_code 2, then 0, on consecutive pushes; keys[2] and keys[0] both set.
- Overflow: evt_ready=0, five distinct presses -> FIFO holds the first four in order and overflow=1. Then, with the FIFO full, pop and push in the same cycle -> count stays 4 and order is preserved.
- Macro undefined: row[1] low during a single col3 sample -> keys[13]=1 and event D on that scan.
